parity_pipe: RTL and testbench

Pipelined, parametrised parity unit for the fixed-point execution path. It generalises the single-word LSB-parity function to any multiple of 32 bits and adds three operating modes, including a running accumulator. It has a valid/ready handshake on both sides and carries a tag so the issue logic can match results to instructions. It sits beside the ALU and is fed from the operand-fetch stage.

---
 rtl/parity_pipe_pkg.sv | 20 ++
 rtl/parity_pipe_byte_parity.sv | 11 +
 rtl/parity_pipe.sv | 125 ++++++++++++
 tb/tb_parity_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pipe_pkg.sv
// Shared types for the parity unit: operation encoding, default word width
// and the reduction helper used to fold per-lane parity into segment results.
package Pu_types;

  localparam int DWIDTH = 32;

  typedef logic [DWIDTH-1:0] Word;

  typedef enum logic [1:0] {
    PAR_WORD = 2'd0,
    PAR_BYTE = 2'd1,
    PAR_ACC  = 2'd2
  } Parity_op;

  // XOR of the four byte-LSB flags that make up one 32-bit segment.
  function automatic logic seg_lsb_parity(input logic [3:0] lb);
    return ^lb;
  endfunction

endpackage

// File: rtl/parity_pipe_byte_parity.sv
// One byte lane of the parity front end: full parity of the byte and its LSB.
module byte_parity (
  input  logic [7:0] data_i,
  output logic       parity_o,
  output logic       lsb_o
);

  assign parity_o = ^data_i;
  assign lsb_o    = data_i[0];

endmodule

// File: rtl/parity_pipe.sv
// Two-stage parity unit with valid/ready on both sides, tag pass-through and a
// running parity accumulator updated only when an ACC op enters stage 2.
module parity_pipe #(
  parameter int DWIDTH = Pu_types::DWIDTH,
  parameter int TAGW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [TAGW-1:0]   in_tag,
  input  logic              acc_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [TAGW-1:0]   out_tag
);
  import Pu_types::*;

  localparam int NB   = DWIDTH / 8;
  localparam int NSEG = DWIDTH / 32;

  logic [NB-1:0]     bp_in, lb_in;

  logic              vld_p1_q, vld_p1_d;
  logic [NB-1:0]     bp_p1_q, lb_p1_q;
  logic [1:0]        op_p1_q;
  logic [TAGW-1:0]   tag_p1_q;

  logic              vld_p2_q, vld_p2_d;
  logic [DWIDTH-1:0] data_p2_q, data_p2_d;
  logic [TAGW-1:0]   tag_p2_q, tag_p2_d;
  logic              acc_q, acc_d;

  logic              s2_ready, load_p1, move_p2;
  logic              acc_base, acc_new;
  logic [DWIDTH-1:0] result;

  function automatic logic [DWIDTH-1:0] form_result(
    input logic [1:0]    op,
    input logic [NB-1:0] bp,
    input logic [NB-1:0] lb,
    input logic          acc
  );
    logic [DWIDTH-1:0] r;
    r = '0;
    case (op)
      PAR_WORD: for (int k = 0; k < NSEG; k++) r[32*k] = seg_lsb_parity(lb[4*k +: 4]);
      PAR_ACC:  r[0] = acc;
      default:  for (int i = 0; i < NB; i++) r[8*i] = bp[i];
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < NB; i++) begin : g_lane
    byte_parity u_byte_parity (
      .data_i  (in_data[8*i +: 8]),
      .parity_o(bp_in[i]),
      .lsb_o   (lb_in[i])
    );
  end

  always_comb begin
    s2_ready = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_ready;
    load_p1  = in_valid && in_ready;
    move_p2  = vld_p1_q && s2_ready;
  end

  // Stage 0 -> 1: capture lane parity, LSBs, op and tag.
  always_comb begin
    vld_p1_d = vld_p1_q;
    if (in_ready) vld_p1_d = in_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (load_p1) begin
      bp_p1_q  <= bp_in;
      lb_p1_q  <= lb_in;
      op_p1_q  <= in_op;
      tag_p1_q <= in_tag;
    end
  end

  // Stage 1 -> 2: form the result; a same-cycle clear is applied before the ACC fold.
  always_comb begin
    acc_base  = acc_clear ? 1'b0 : acc_q;
    acc_new   = acc_base ^ (^bp_p1_q);
    result    = form_result(op_p1_q, bp_p1_q, lb_p1_q, acc_new);

    vld_p2_d  = s2_ready ? vld_p1_q : vld_p2_q;
    data_p2_d = move_p2 ? result : data_p2_q;
    tag_p2_d  = move_p2 ? tag_p1_q : tag_p2_q;

    acc_d = acc_q;
    if (acc_clear) acc_d = 1'b0;
    if (move_p2 && op_p1_q == PAR_ACC) acc_d = acc_new;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      tag_p2_q  <= '0;
      acc_q     <= 1'b0;
    end else begin
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      tag_p2_q  <= tag_p2_d;
      acc_q     <= acc_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_parity_pipe.sv
// Directed bench for parity_pipe: 32-bit instance for the main scenarios and a
// 64-bit instance for segment-wise WORD/BYTE results.
module tb_parity_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, acc_clear, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_tag, out_tag;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [1:0]  in_op64;
  logic [63:0] in_data64, out_data64;
  logic [4:0]  in_tag64, out_tag64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] q_data[$];
  logic [4:0]  q_tag[$];
  int          q_cyc[$];

  parity_pipe #(.DWIDTH(32), .TAGW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_tag(in_tag), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  parity_pipe #(.DWIDTH(64), .TAGW(5)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_op(in_op64),
    .in_data(in_data64), .in_tag(in_tag64), .acc_clear(1'b0),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_data(out_data64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every result the consumer takes (transfer happens at the following rising edge).
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_tag.push_back(out_tag);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [4:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_tag   = t;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic q_clear();
    q_data.delete();
    q_tag.delete();
    q_cyc.delete();
  endtask

  task automatic wait_n(input int n);
    int b;
    b = 0;
    while (q_data.size() < n && b < 30) begin
      tick();
      b++;
    end
    repeat (3) tick();
  endtask

  task automatic pulse_clear();
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_word();
    int t0, t1;
    q_clear();
    t0 = cyc; drive(2'd0, 32'h01010100, 5'd3); tick();
    t1 = cyc; drive(2'd0, 32'h01000001, 5'd4); tick();
    idle();
    wait_n(2);
    checks++; if (q_data.size() != 2) begin errors++; $display("FAIL word_count got %0d want 2", q_data.size()); end
    checks++; if (q_data[0] !== 32'h00000001) begin errors++; $display("FAIL word0_data got %h want 00000001", q_data[0]); end
    checks++; if (q_data[1] !== 32'h00000000) begin errors++; $display("FAIL word1_data got %h want 00000000", q_data[1]); end
    checks++; if (q_tag[0] !== 5'd3 || q_tag[1] !== 5'd4) begin errors++; $display("FAIL word_tags got %0d,%0d want 3,4", q_tag[0], q_tag[1]); end
    checks++; if (q_cyc[0] - t0 != 2) begin errors++; $display("FAIL word0_latency got %0d want 2", q_cyc[0] - t0); end
    checks++; if (q_cyc[1] - t1 != 2) begin errors++; $display("FAIL word1_latency got %0d want 2", q_cyc[1] - t1); end
  endtask

  task automatic test_byte();
    q_clear();
    drive(2'd1, 32'h03070080, 5'd5); tick();
    drive(2'd3, 32'h03070080, 5'd6); tick();
    drive(2'd1, 32'hFFFFFFFF, 5'd7); tick();
    drive(2'd1, 32'h01000001, 5'd8); tick();
    idle();
    wait_n(4);
    checks++; if (q_data.size() != 4) begin errors++; $display("FAIL byte_count got %0d want 4", q_data.size()); end
    checks++; if (q_data[0] !== 32'h00010001) begin errors++; $display("FAIL byte_data got %h want 00010001", q_data[0]); end
    checks++; if (q_data[1] !== 32'h00010001) begin errors++; $display("FAIL byte_reserved_op got %h want 00010001", q_data[1]); end
    checks++; if (q_data[2] !== 32'h00000000) begin errors++; $display("FAIL byte_all_ones got %h want 00000000", q_data[2]); end
    checks++; if (q_data[3] !== 32'h01000001) begin errors++; $display("FAIL byte_edges got %h want 01000001", q_data[3]); end
  endtask

  task automatic test_acc();
    logic [31:0] exp_d [4];
    exp_d = '{32'h1, 32'h1, 32'h1, 32'h0};
    pulse_clear();
    q_clear();
    drive(2'd2, 32'h00000001, 5'd1); tick();
    drive(2'd2, 32'h00000003, 5'd2); tick();
    drive(2'd2, 32'hFFFFFFFF, 5'd3); tick();
    drive(2'd2, 32'h00000007, 5'd4); tick();
    idle();
    wait_n(4);
    checks++; if (q_data.size() != 4) begin errors++; $display("FAIL acc_count got %0d want 4", q_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== exp_d[i] || q_tag[i] !== 5'(i + 1))
        begin errors++; $display("FAIL acc_seq[%0d] got %h tag %0d want %h tag %0d", i, q_data[i], q_tag[i], exp_d[i], i + 1); end
    end
  endtask

  task automatic test_acc_clear_same_cycle();
    q_clear();
    drive(2'd2, 32'h00000001, 5'd10); tick();
    idle();
    wait_n(1);
    drive(2'd2, 32'h00000001, 5'd11); tick();
    idle();
    acc_clear = 1'b1; tick();
    acc_clear = 1'b0;
    wait_n(2);
    drive(2'd2, 32'h00000000, 5'd12); tick();
    idle();
    wait_n(3);
    checks++; if (q_data.size() != 3) begin errors++; $display("FAIL accclr_count got %0d want 3", q_data.size()); end
    checks++; if (q_data[0] !== 32'h1) begin errors++; $display("FAIL accclr_setup got %h want 00000001", q_data[0]); end
    checks++; if (q_data[1] !== 32'h1) begin errors++; $display("FAIL accclr_same_cycle got %h want 00000001", q_data[1]); end
    checks++; if (q_data[2] !== 32'h1) begin errors++; $display("FAIL accclr_after got %h want 00000001", q_data[2]); end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    q_clear();
    out_ready = 1'b0;
    drive(2'd2, 32'h00000001, 5'd1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first got %0b want 1", in_ready); end
    tick();
    drive(2'd2, 32'h00000001, 5'd2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_second got %0b want 1", in_ready); end
    tick();
    drive(2'd2, 32'h00000001, 5'd3);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1 || out_tag !== 5'd1 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d] got v%0b d%h t%0d r%0b want v1 d00000001 t1 r0", i, out_valid, out_data, out_tag, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %0b want 1", in_ready); end
    tick();
    idle();
    wait_n(3);
    repeat (4) tick();
    checks++; if (q_data.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", q_data.size()); end
    checks++; if (q_tag[0] !== 5'd1 || q_tag[1] !== 5'd2 || q_tag[2] !== 5'd3)
      begin errors++; $display("FAIL bp_order got %0d,%0d,%0d want 1,2,3", q_tag[0], q_tag[1], q_tag[2]); end
    checks++; if (q_data[0] !== 32'h1 || q_data[1] !== 32'h0 || q_data[2] !== 32'h1)
      begin errors++; $display("FAIL bp_acc got %h,%h,%h want 1,0,1", q_data[0], q_data[1], q_data[2]); end
  endtask

  task automatic test_reset_midflight();
    pulse_clear();
    out_ready = 1'b0;
    drive(2'd2, 32'h00000001, 5'd7); tick();
    drive(2'd2, 32'h00000001, 5'd8); tick();
    idle();
    checks++; if (out_valid !== 1'b1 || out_tag !== 5'd7) begin errors++; $display("FAIL rst_inflight got v%0b t%0d want v1 t7", out_valid, out_tag); end
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0 || out_tag !== 5'd0) begin errors++; $display("FAIL rst_async_outputs got %h t%0d want 0 t0", out_data, out_tag); end
    tick(); tick();
    reset = 1'b1;
    out_ready = 1'b1;
    q_clear();
    repeat (5) tick();
    checks++; if (q_data.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got %0d results v%0b want 0 v0", q_data.size(), out_valid); end
    drive(2'd2, 32'h00000001, 5'd9); tick();
    idle();
    wait_n(1);
    checks++; if (q_data.size() != 1 || q_data[0] !== 32'h1 || q_tag[0] !== 5'd9)
      begin errors++; $display("FAIL rst_acc_new got n%0d %h t%0d want n1 00000001 t9", q_data.size(), q_data[0], q_tag[0]); end
  endtask

  task automatic test_wide();
    logic [63:0] exp64 [2];
    logic [63:0] vec64 [2];
    logic [1:0]  op64  [2];
    logic [63:0] got;
    logic        seen;
    vec64 = '{64'h00000001_01010100, 64'h80000000_00000001};
    op64  = '{2'd0, 2'd1};
    exp64 = '{64'h00000001_00000001, 64'h01000000_00000001};
    out_ready64 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid64 = 1'b1; in_op64 = op64[i]; in_data64 = vec64[i]; in_tag64 = 5'(20 + i);
      tick();
      in_valid64 = 1'b0;
      seen = 1'b0; got = '0;
      for (int b = 0; b < 6 && !seen; b++) begin
        @(negedge clk);
        if (out_valid64) begin seen = 1'b1; got = out_data64; end
      end
      tick();
      checks++;
      if (!seen || got !== exp64[i]) begin errors++; $display("FAIL wide[%0d] got %h seen %0b want %h", i, got, seen, exp64[i]); end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_op = 2'd0; in_data = '0; in_tag = '0;
    acc_clear = 1'b0; out_ready = 1'b1;
    in_valid64 = 1'b0; in_op64 = 2'd0; in_data64 = '0; in_tag64 = '0; out_ready64 = 1'b1;
    test_reset();
    test_word();
    test_byte();
    test_acc();
    test_acc_clear_same_cycle();
    test_back_to_back();
    test_reset_midflight();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
